pc_update_unit: RTL and testbench
=================================

PC_UPDATE_UNIT -- requirements
Module: pc_update_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, value loaded into PC on reset.
REQ-002 Parameter VEC_OPCODE, default 32'h0000_00FD, handler address for code 0 (nonexistent opcode).
REQ-003 Parameter VEC_OVERFLOW, default 32'h0000_00FE, handler address for code 1 (arithmetic overflow).
REQ-004 Parameter VEC_DIVZERO, default 32'h0000_00FF, handler address for code 2 (divide by zero).
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 pc_next  input  32  candidate next PC from the PC-source selector.
REQ-008 pc_write  input  1  unconditional PC write request.
REQ-009 pc_write_cond  input  1  conditional (branch) PC write request.
REQ-010 branch_type  input  2  00 beq, 01 bne, 10 bgt, 11 ble.
REQ-011 zero  input  1  ALU equal flag.
REQ-012 gt  input  1  ALU greater-than flag.
REQ-013 exc_req  input  1  exception request, one-cycle pulse.
REQ-014 exc_code  input  2  exception cause, valid with exc_req; 11 reserved.
REQ-015 pc  output  32  current program counter.
REQ-016 epc  output  32  saved exception PC.
REQ-017 exc_busy  output  1  high while the exception sequence is in progress.
REQ-018 pc_update_count  output  32  number of PC writes since reset.

Function
REQ-019 Branch condition taken = zero (beq), ~zero (bne), gt (bgt), ~gt (ble).
REQ-020 PC write enable = pc_write OR (pc_write_cond AND taken), evaluated only in state RUN.
REQ-021 With write enable high in RUN, PC takes pc_next at the next edge; otherwise PC holds.
REQ-022 FSM states: RUN, EXC_SAVE, EXC_JUMP; reset state RUN.
REQ-023 RUN: exc_req with exc_code 00/01/10 -> EXC_SAVE and latch cause; exc_req with code 11 is ignored.
REQ-024 exc_req has priority over pc_write/pc_write_cond in the same RUN cycle; no PC write occurs that cycle.
REQ-025 EXC_SAVE: epc <= pc - 4 (32-bit modulo, so 0 wraps to 32'hFFFF_FFFC); -> EXC_JUMP.
REQ-026 EXC_JUMP: PC <= vector selected by the latched cause; -> RUN.
REQ-027 exc_busy is high in EXC_SAVE and EXC_JUMP and low in RUN; it is a registered state decode.
REQ-028 In EXC_SAVE and EXC_JUMP, pc_write, pc_write_cond and exc_req are ignored.
REQ-029 Exception entry latency: handler address is visible on pc 2 cycles after the exc_req edge.
REQ-030 pc_update_count increments by 1 on every PC load: RUN writes and the EXC_JUMP load.
REQ-031 pc_update_count wraps from 32'hFFFF_FFFF to 0.
REQ-032 epc holds its value except in EXC_SAVE.

Reset
REQ-033 While reset is high at a rising edge: pc = RESET_PC, epc = 0, pc_update_count = 0, state = RUN, exc_busy = 0.
REQ-034 Reset mid-exception (EXC_SAVE or EXC_JUMP) aborts the sequence; no vector is loaded.
REQ-035 Reset has priority over every other input.

Verification
REQ-036 Reset, then pc_write=1 with pc_next=32'h4 for one cycle -> pc=32'h4, pc_update_count=1.
REQ-037 pc=32'h10, pc_write_cond=1, branch_type=01, zero=1, pc_next=32'h40 -> pc stays 32'h10, count unchanged; repeat with zero=0 -> pc=32'h40.
REQ-038 pc=32'h20, exc_req=1, exc_code=01, pc_write=1 in the same cycle -> next cycle exc_busy=1, pc=32'h20; then epc=32'h1C; then pc=32'hFE, exc_busy=0.
REQ-039 pc=0, exc_req=1, exc_code=10 -> epc=32'hFFFF_FFFC, pc=32'hFF.
REQ-040 exc_req with exc_code=11 -> no state change, exc_busy stays 0.
REQ-041 Reset asserted during EXC_SAVE -> pc=RESET_PC, epc=0, exc_busy=0 the next cycle; the vector is never loaded.

Source files
------------

// File: rtl/pc_update_unit.sv
// -----------------------------------------------------------------------------
// pc_update_unit
//
// Holds the architectural program counter of a multi-cycle CPU. In normal
// operation the PC is loaded from the PC-source selector when an unconditional
// write is requested, or when a conditional (branch) write is requested and the
// branch condition derived from the ALU flags holds. An exception request takes
// the unit through a short sequence: save the faulting PC (pc - 4) into epc,
// then load the handler address chosen by the exception cause.
//
// Parameters
//   RESET_PC      PC value after reset
//   VEC_OPCODE    handler address for cause 0 (nonexistent opcode)
//   VEC_OVERFLOW  handler address for cause 1 (arithmetic overflow)
//   VEC_DIVZERO   handler address for cause 2 (divide by zero)
//
// Ports
//   clk              in   1   clock, all state changes on the rising edge
//   reset            in   1   synchronous active-high reset
//   pc_next          in  32   candidate next PC
//   pc_write         in   1   unconditional PC write request
//   pc_write_cond    in   1   conditional (branch) PC write request
//   branch_type      in   2   00 beq, 01 bne, 10 bgt, 11 ble
//   zero             in   1   ALU equal flag
//   gt               in   1   ALU greater-than flag
//   exc_req          in   1   exception request (single-cycle pulse)
//   exc_code         in   2   exception cause, 11 is reserved and ignored
//   pc               out 32   current program counter
//   epc              out 32   saved exception PC
//   exc_busy         out  1   exception sequence in progress
//   pc_update_count  out 32   number of PC loads since reset (wraps)
// -----------------------------------------------------------------------------
module pc_update_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] VEC_OPCODE   = 32'h0000_00FD,
    parameter logic [31:0] VEC_OVERFLOW = 32'h0000_00FE,
    parameter logic [31:0] VEC_DIVZERO  = 32'h0000_00FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  branch_type,
    input  logic        zero,
    input  logic        gt,
    input  logic        exc_req,
    input  logic [1:0]  exc_code,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic        exc_busy,
    output logic [31:0] pc_update_count
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StExcSave = 2'b01,
        StExcJump = 2'b10
    } state_e;

    localparam logic [1:0] CodeReserved = 2'b11;

    state_e      state_q, state_d;
    logic [1:0]  cause_q;
    logic [31:0] pc_q;
    logic [31:0] epc_q;
    logic [31:0] count_q;
    logic        busy_q;

    logic        taken;
    logic        exc_accept;
    logic [31:0] vec_addr;

    // Decoded per-cycle actions, produced by the output process.
    logic        run_pc_we;
    logic        cause_we;
    logic        epc_we;
    logic        vec_load;

    // -------------------------------------------------------------------------
    // Branch condition from the ALU flags
    // -------------------------------------------------------------------------
    always_comb begin
        taken = 1'b0;
        unique case (branch_type)
            2'b00:   taken = zero;
            2'b01:   taken = ~zero;
            2'b10:   taken = gt;
            2'b11:   taken = ~gt;
            default: taken = 1'b0;
        endcase
    end

    // A reserved cause is dropped entirely, so it never wins over a PC write.
    assign exc_accept = exc_req && (exc_code != CodeReserved);

    // -------------------------------------------------------------------------
    // Handler address for the latched cause
    // -------------------------------------------------------------------------
    always_comb begin
        vec_addr = VEC_OPCODE;
        unique case (cause_q)
            2'b00:   vec_addr = VEC_OPCODE;
            2'b01:   vec_addr = VEC_OVERFLOW;
            2'b10:   vec_addr = VEC_DIVZERO;
            // Never latched; kept on a defined handler for safety.
            default: vec_addr = VEC_OPCODE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (exc_accept) begin
                    state_d = StExcSave;
                end
            end
            StExcSave: state_d = StExcJump;
            StExcJump: state_d = StRun;
            default:   state_d = StRun;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output decode
    // -------------------------------------------------------------------------
    always_comb begin
        run_pc_we = 1'b0;
        cause_we  = 1'b0;
        epc_we    = 1'b0;
        vec_load  = 1'b0;
        unique case (state_q)
            StRun: begin
                cause_we  = exc_accept;
                // The exception takes the cycle; any PC write request is lost.
                run_pc_we = ~exc_accept && (pc_write || (pc_write_cond && taken));
            end
            StExcSave: epc_we   = 1'b1;
            StExcJump: vec_load = 1'b1;
            default: begin
                run_pc_we = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            epc_q   <= 32'h0000_0000;
            count_q <= 32'h0000_0000;
            cause_q <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            if (vec_load) begin
                pc_q <= vec_addr;
            end else if (run_pc_we) begin
                pc_q <= pc_next;
            end

            if (vec_load || run_pc_we) begin
                count_q <= count_q + 32'd1;
            end

            // Modulo subtraction: a PC of 0 yields 32'hFFFF_FFFC.
            if (epc_we) begin
                epc_q <= pc_q - 32'd4;
            end

            if (cause_we) begin
                cause_q <= exc_code;
            end

            // Registered decode of the upcoming state keeps exc_busy glitch-free.
            busy_q <= (state_d != StRun);
        end
    end

    assign pc              = pc_q;
    assign epc             = epc_q;
    assign exc_busy        = busy_q;
    assign pc_update_count = count_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_update_unit
//
// Stimulus is applied on the falling edge. Each time inputs are applied, the
// architectural effect of that cycle is computed by a reference model and the
// expected register state is pushed into a queue. A separate monitor samples
// the outputs just after every rising edge and pops one expectation per cycle.
// -----------------------------------------------------------------------------
module tb_pc_update_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_1000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] cnt;
        logic        busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_next = '0;
    logic        pc_write = 1'b0;
    logic        pc_write_cond = 1'b0;
    logic [1:0]  branch_type = 2'b00;
    logic        zero = 1'b0;
    logic        gt = 1'b0;
    logic        exc_req = 1'b0;
    logic [1:0]  exc_code = 2'b00;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        exc_busy;
    logic [31:0] pc_update_count;

    pc_update_unit #(
        .RESET_PC(RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_next        (pc_next),
        .pc_write       (pc_write),
        .pc_write_cond  (pc_write_cond),
        .branch_type    (branch_type),
        .zero           (zero),
        .gt             (gt),
        .exc_req        (exc_req),
        .exc_code       (exc_code),
        .pc             (pc),
        .epc            (epc),
        .exc_busy       (exc_busy),
        .pc_update_count(pc_update_count)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    // Reference model: architectural state plus the remaining steps of an
    // exception sequence (2 = save pending, 1 = jump pending, 0 = none).
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_epc = '0;
    logic [31:0] m_cnt = '0;
    int          m_steps = 0;
    int          m_cause = 0;
    logic [31:0] handler[3] = '{32'h0000_00FD, 32'h0000_00FE, 32'h0000_00FF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Apply one cycle of inputs and record what the design must show afterwards.
    task automatic step(input bit rst, input logic [31:0] nxt, input bit pw, input bit pwc,
                        input logic [1:0] bt, input bit z, input bit g,
                        input bit er, input logic [1:0] ec);
        bit   cond;
        exp_t e;
        @(negedge clk);
        reset = rst; pc_next = nxt; pc_write = pw; pc_write_cond = pwc;
        branch_type = bt; zero = z; gt = g; exc_req = er; exc_code = ec;

        if (rst) begin
            m_pc = RESET_PC; m_epc = 0; m_cnt = 0; m_steps = 0;
        end else if (m_steps == 2) begin
            m_epc = m_pc - 32'd4;
            m_steps = 1;
        end else if (m_steps == 1) begin
            m_pc = handler[m_cause];
            m_cnt = m_cnt + 1;
            m_steps = 0;
        end else if (er && ec != 2'b11) begin
            m_cause = int'(ec);
            m_steps = 2;
        end else begin
            case (bt)
                2'b00: cond = z;
                2'b01: cond = !z;
                2'b10: cond = g;
                default: cond = !g;
            endcase
            if (pw || (pwc && cond)) begin
                m_pc = nxt;
                m_cnt = m_cnt + 1;
            end
        end
        e.pc = m_pc; e.epc = m_epc; e.cnt = m_cnt; e.busy = (m_steps != 0);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(0, 32'h0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
    endtask

    task automatic load_pc(input logic [31:0] v);
        step(0, v, 1, 0, 2'b00, 0, 0, 0, 2'b00);
    endtask

    // Monitor: one expectation per rising edge once stimulus has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", pc, e.pc);
                check("epc", epc, e.epc);
                check("pc_update_count", pc_update_count, e.cnt);
                check("exc_busy", {31'b0, exc_busy}, {31'b0, e.busy});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        step(1, 32'h0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
        step(1, 32'h0, 0, 0, 2'b00, 0, 0, 0, 2'b00);

        // Unconditional write after reset.
        load_pc(32'h4);
        // bne with zero=1 holds, zero=0 takes.
        load_pc(32'h10);
        step(0, 32'h40, 0, 1, 2'b01, 1, 0, 0, 2'b00);
        step(0, 32'h40, 0, 1, 2'b01, 0, 0, 0, 2'b00);
        // Remaining branch types, taken and not taken.
        step(0, 32'h50, 0, 1, 2'b00, 1, 0, 0, 2'b00);
        step(0, 32'h54, 0, 1, 2'b00, 0, 1, 0, 2'b00);
        step(0, 32'h60, 0, 1, 2'b10, 0, 1, 0, 2'b00);
        step(0, 32'h64, 0, 1, 2'b10, 1, 0, 0, 2'b00);
        step(0, 32'h70, 0, 1, 2'b11, 0, 0, 0, 2'b00);
        step(0, 32'h74, 0, 1, 2'b11, 0, 1, 0, 2'b00);

        // Overflow exception beats a simultaneous write; inputs ignored while busy.
        load_pc(32'h20);
        step(0, 32'h80, 1, 0, 2'b00, 0, 0, 1, 2'b01);
        step(0, 32'h84, 1, 1, 2'b01, 0, 0, 1, 2'b00);
        step(0, 32'h88, 1, 0, 2'b00, 0, 0, 1, 2'b10);
        idle();

        // Divide-by-zero from pc 0: epc wraps.
        load_pc(32'h0);
        step(0, 32'h0, 0, 0, 2'b00, 0, 0, 1, 2'b10);
        idle(); idle(); idle();

        // Reserved cause is ignored, with and without a concurrent write.
        step(0, 32'h0, 0, 0, 2'b00, 0, 0, 1, 2'b11);
        step(0, 32'h300, 1, 0, 2'b00, 0, 0, 1, 2'b11);

        // Reset during the save step, then during the jump step.
        step(0, 32'h0, 0, 0, 2'b00, 0, 0, 1, 2'b00);
        step(1, 32'h0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
        idle(); idle(); idle();
        load_pc(32'h500);
        step(0, 32'h0, 0, 0, 2'b00, 0, 0, 1, 2'b00);
        idle();
        step(1, 32'h0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
        idle(); idle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0, $urandom, 1'($urandom_range(0, 3) == 0),
                 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 9) == 0, 2'($urandom));
        end

        idle();
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
